// File: rtl/apb_uart_tx_if.sv
`default_nettype none
// ============================================================================
// apb_uart_tx_if : APB slave bus bundle for the UART transmitter
// Rev 1.0
// ============================================================================
interface apb_uart_tx_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );
endinterface
`default_nettype wire

// File: rtl/apb_uart_tx.sv
`default_nettype none
// ============================================================================
// apb_uart_tx : APB slave UART transmitter, TX FIFO feeding an 8N1 serialiser
// Rev 1.0
// ============================================================================
module apb_uart_tx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 16
) (
  input  wire logic        pclk,
  input  wire logic        Reset,
  apb_uart_tx_if.slave     bus,
  output      logic        tx,
  output      logic        tx_busy
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_ovf;
  logic               r_en;
  logic [15:0]        r_div;

  state_t             r_state;
  logic [15:0]        r_baud;
  logic [15:0]        r_sdiv;
  logic [2:0]         r_idx;
  logic [7:0]         r_shift;
  logic               r_tx;
  logic               r_busy;

  logic               w_access;
  logic               w_wr;
  logic               w_rd;
  logic               w_push;
  logic               w_push_ok;
  logic               w_pop;
  logic               w_empty;
  logic               w_full;
  logic               w_bit_end;
  logic               w_line;
  logic [31:0]        w_rdata;
  logic               w_unused;

  assign w_access  = bus.psel & bus.penable;
  assign w_wr      = w_access & bus.pwrite;
  assign w_rd      = w_access & ~bus.pwrite;
  assign w_push    = w_wr && (bus.paddr == 5'h00);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_DEPTH);
  assign w_bit_end = (r_baud == r_sdiv - 16'd1);
  // A pop happens from IDLE, or at the last STOP cycle so frames run back to back
  assign w_pop     = ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end))
                     && r_en && !w_empty;
  assign w_push_ok = w_push && ((r_count < c_DEPTH) || w_pop);
  assign w_unused  = &{1'b0, bus.pwdata[31:16]};

  always_ff @(posedge pclk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= bus.pwdata[7:0];
    end
  end

  always_ff @(posedge pclk or posedge Reset) begin
    if (Reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge pclk or posedge Reset) begin
    if (Reset) begin
      r_div <= 16'(DEFAULT_DIV);
      r_en  <= 1'b1;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr && (bus.paddr == 5'h08)) begin
        r_div <= (bus.pwdata[15:0] == 16'd0) ? 16'd1 : bus.pwdata[15:0];
      end
      if (w_wr && (bus.paddr == 5'h0C)) begin
        r_en <= bus.pwdata[0];
        if (bus.pwdata[1]) r_ovf <= 1'b0;
      end
      if (w_push && !w_push_ok) r_ovf <= 1'b1;
    end
  end

  always_comb begin
    w_line = 1'b1;
    case (r_state)
      S_START: w_line = 1'b0;
      S_DATA:  w_line = r_shift[r_idx];
      default: w_line = 1'b1;
    endcase
  end

  // tx/tx_busy are registered copies of the state, so the whole line lags by one cycle
  always_ff @(posedge pclk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_sdiv  <= 16'd1;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_tx   <= w_line;
      r_busy <= (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift <= r_mem[r_rptr];
            r_sdiv  <= r_div;
            r_baud  <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_idx   <= '0;
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_idx == 3'd7) r_state <= S_STOP;
            else               r_idx   <= r_idx + 3'd1;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= r_mem[r_rptr];
              r_sdiv  <= r_div;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (bus.paddr)
        5'h04:   w_rdata = {16'd0, 8'(r_count), 4'd0, r_ovf, r_busy, w_full, w_empty};
        5'h08:   w_rdata = {16'd0, r_div};
        5'h0C:   w_rdata = {31'd0, r_en};
        default: w_rdata = '0;
      endcase
    end
  end

  assign bus.prdata = w_rdata;
  assign bus.pready = w_access;
  assign tx         = r_tx;
  assign tx_busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_apb_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_apb_uart_tx : directed bench with a frame-level line model for apb_uart_tx
// Rev 1.0
// ============================================================================
module tb_apb_uart_tx;

  logic pclk = 1'b0;
  logic Reset;
  logic tx;
  logic tx_busy;

  always #5 pclk = ~pclk;

  apb_uart_tx_if u_if();

  apb_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(16)) dut (
    .pclk    (pclk),
    .Reset   (Reset),
    .bus     (u_if),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int busy_cnt = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Line model: a frame is {stop=1, byte, start=0} shifted out LSB first, DIV cycles per bit
  function automatic logic frame_bit(logic [7:0] b, int p);
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return b[p-1];
  endfunction

  logic [7:0] m_q[$];
  bit         m_ovf;
  int         m_div;
  bit         m_en;
  bit         m_active;
  int         m_ip;
  logic [7:0] m_fb;
  int         m_fd = 1;
  logic       m_tx = 1'b1;
  logic       m_busy = 1'b0;
  int         m_pops = 0;
  bit         m_pop;
  int         m_pre;

  always @(posedge pclk or posedge Reset) begin
    if (Reset) begin
      m_q.delete();
      m_ovf = 0; m_div = 16; m_en = 1; m_active = 0; m_ip = 0;
      m_tx = 1'b1; m_busy = 1'b0;
    end else begin
      m_tx   = m_active ? frame_bit(m_fb, m_ip / m_fd) : 1'b1;
      m_busy = m_active;
      if (m_active) begin
        m_ip++;
        if (m_ip == 10 * m_fd) m_active = 0;
      end
      m_pre = m_q.size();
      m_pop = 0;
      if (!m_active && m_en && m_pre > 0) begin
        m_fb = m_q.pop_front();
        m_fd = m_div; m_ip = 0; m_active = 1; m_pop = 1; m_pops++;
      end
      if (u_if.psel && u_if.penable && u_if.pwrite) begin
        case (u_if.paddr)
          5'h00: if (m_pre < 8 || m_pop) m_q.push_back(u_if.pwdata[7:0]); else m_ovf = 1;
          5'h08: m_div = (u_if.pwdata[15:0] == 16'd0) ? 1 : int'(u_if.pwdata[15:0]);
          5'h0C: begin m_en = u_if.pwdata[0]; if (u_if.pwdata[1]) m_ovf = 0; end
          default: ;
        endcase
      end
    end
  end

  always @(negedge pclk) begin
    if (chk_en) begin
      check("tx_line", {31'd0, tx}, {31'd0, m_tx});
      check("tx_busy", {31'd0, tx_busy}, {31'd0, m_busy});
    end
    if (tx_busy === 1'b1) busy_cnt++;
  end

  task automatic apb_write(logic [4:0] a, logic [31:0] d);
    u_if.psel = 1; u_if.penable = 0; u_if.pwrite = 1; u_if.paddr = a; u_if.pwdata = d;
    @(negedge pclk);
    u_if.penable = 1;
    @(negedge pclk);
    u_if.psel = 0; u_if.penable = 0; u_if.pwrite = 0;
  endtask

  task automatic apb_read(string name, logic [4:0] a, logic [31:0] exp, logic [31:0] mask);
    u_if.psel = 1; u_if.penable = 0; u_if.pwrite = 0; u_if.paddr = a;
    @(negedge pclk);
    u_if.penable = 1;
    #1;
    check(name, u_if.prdata & mask, exp);
    @(negedge pclk);
    u_if.psel = 0; u_if.penable = 0;
  endtask

  task automatic wait_pops(int target, int budget);
    int n = 0;
    while (m_pops < target && n < budget) begin
      @(negedge pclk);
      n++;
    end
    check("wait_pop", {31'd0, m_pops >= target}, 32'd1);
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((m_active || m_busy || m_q.size() != 0) && n < budget) begin
      @(negedge pclk);
      n++;
    end
    repeat (2) @(negedge pclk);
    check("idle_busy", {31'd0, tx_busy}, 32'd0);
  endtask

  logic       s_tx   [60];
  logic       s_busy [60];
  logic [9:0] pat;
  int         b0;
  int         p0;
  int         nb;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    u_if.psel = 0; u_if.penable = 0; u_if.pwrite = 0; u_if.paddr = '0; u_if.pwdata = '0;
    Reset = 1'b1;
    repeat (3) @(negedge pclk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_pready", {31'd0, u_if.pready}, 32'd0);
    check("rst_prdata", u_if.prdata, 32'd0);
    Reset = 1'b0;
    chk_en = 1'b1;
    @(negedge pclk);
    apb_read("rst_status", 5'h04, 32'h0000_0001, 32'hFFFF_FFFF);
    apb_read("rst_baud",   5'h08, 32'd16,        32'hFFFF_FFFF);
    apb_read("rst_ctrl",   5'h0C, 32'd1,         32'hFFFF_FFFF);

    // 0xA5 at DIV=4, sampled every cycle from the write edge
    apb_write(5'h08, 32'd4);
    apb_write(5'h00, 32'hA5);
    for (int k = 0; k < 60; k++) begin
      s_tx[k] = tx; s_busy[k] = tx_busy;
      @(negedge pclk);
    end
    pat = {1'b1, 8'hA5, 1'b0};
    check("t1_lat_e1", {31'd0, s_tx[1]}, 32'd1);
    for (int k = 2; k < 42; k++)
      check($sformatf("t1_tx%0d", k), {31'd0, s_tx[k]}, {31'd0, pat[(k-2)/4]});
    check("t1_after", {31'd0, s_tx[42]}, 32'd1);
    nb = 0;
    for (int k = 0; k < 60; k++) if (s_busy[k]) nb++;
    check("t1_busy_len", nb, 32'd40);
    check("t1_busy_first", {31'd0, s_busy[2]}, 32'd1);

    // Three back-to-back frames
    b0 = busy_cnt; p0 = m_pops;
    apb_write(5'h00, 32'h01);
    apb_write(5'h00, 32'h02);
    apb_write(5'h00, 32'h03);
    for (int k = 0; k < 3; k++) begin
      wait_pops(p0 + k + 1, 200);
      apb_read($sformatf("t2_count%0d", k), 5'h04, (2 - k) << 8, 32'h0000_FF00);
    end
    wait_idle(300);
    check("t2_busy_len", busy_cnt - b0, 32'd120);

    // Overflow with EN=0, then release
    apb_write(5'h0C, 32'h0);
    for (int k = 0; k < 9; k++) apb_write(5'h00, 32'h10 + k);
    apb_read("t3_status", 5'h04, 32'h0000_080A, 32'hFFFF_FFFF);
    b0 = busy_cnt;
    apb_write(5'h0C, 32'h3);
    apb_read("t3_ovf_clr", 5'h04, 32'h0000_0700, 32'h0000_FF08);
    wait_idle(1000);
    check("t3_busy_len", busy_cnt - b0, 32'd320);
    apb_read("t3_status_end", 5'h04, 32'h0000_0001, 32'hFFFF_FFFF);

    // Divisor change mid-frame applies only to the next frame
    b0 = busy_cnt;
    apb_write(5'h00, 32'h3C);
    apb_write(5'h00, 32'h55);
    repeat (10) @(negedge pclk);
    apb_write(5'h08, 32'd8);
    apb_read("t4_div", 5'h08, 32'd8, 32'hFFFF_FFFF);
    wait_idle(500);
    check("t4_busy_len", busy_cnt - b0, 32'd120);
    apb_write(5'h08, 32'd0);
    apb_read("t4_div0", 5'h08, 32'd1, 32'hFFFF_FFFF);
    apb_write(5'h08, 32'd4);

    // Reset during the data bits of a 0x00 frame
    p0 = m_pops;
    apb_write(5'h00, 32'h00);
    apb_write(5'h00, 32'h00);
    apb_write(5'h00, 32'h00);
    wait_pops(p0 + 1, 50);
    repeat (12) @(negedge pclk);
    check("t5_pre_tx", {31'd0, tx}, 32'd0);
    #2;
    Reset = 1'b1;
    #1;
    check("t5_rst_tx", {31'd0, tx}, 32'd1);
    check("t5_rst_busy", {31'd0, tx_busy}, 32'd0);
    repeat (2) @(negedge pclk);
    Reset = 1'b0;
    @(negedge pclk);
    apb_read("t5_status", 5'h04, 32'h0000_0001, 32'hFFFF_FFFF);
    apb_read("t5_baud",   5'h08, 32'd16,        32'hFFFF_FFFF);

    // Bus corner cases
    u_if.psel = 0; u_if.penable = 1; u_if.pwrite = 0; u_if.paddr = 5'h04;
    #1;
    check("t6_nosel_prdata", u_if.prdata, 32'd0);
    check("t6_nosel_pready", {31'd0, u_if.pready}, 32'd0);
    @(negedge pclk);
    u_if.psel = 1; u_if.penable = 0;
    #1;
    check("t6_setup_pready", {31'd0, u_if.pready}, 32'd0);
    check("t6_setup_prdata", u_if.prdata, 32'd0);
    @(negedge pclk);
    u_if.penable = 1;
    #1;
    check("t6_acc_pready", {31'd0, u_if.pready}, 32'd1);
    check("t6_acc_prdata", u_if.prdata, 32'h0000_0001);
    @(negedge pclk);
    u_if.psel = 0; u_if.penable = 0;
    apb_read("t6_rd_txdata", 5'h00, 32'd0, 32'hFFFF_FFFF);
    apb_read("t6_rd_0x10",   5'h10, 32'd0, 32'hFFFF_FFFF);
    apb_write(5'h0C, 32'h3);
    apb_read("t6_ctrl", 5'h0C, 32'd1, 32'hFFFF_FFFF);
    wait_idle(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
